// File: rtl/sig_align_if.sv
// Handshake and data bundle for the significand aligner.
// The slave modport is the aligner's view; master is the producer/consumer side.
interface sig_align_if #(
    parameter int EXP_WIDTH  = 4,
    parameter int SIG_WIDTH  = 4,
    parameter int LOW_EXPAND = 2,
    parameter int LANES      = 4
);
    localparam int AW = SIG_WIDTH + 4 + LOW_EXPAND;

    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*EXP_WIDTH-1:0] exp_offset;
    logic [LANES*SIG_WIDTH-1:0] significand;
    logic [LANES-1:0]           sign;
    logic [LANES-1:0]           cmp_sign1;
    logic [LANES-1:0]           cmp_sign2;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*AW-1:0]        adder_num1;
    logic [LANES*AW-1:0]        adder_num2;
    logic [LANES-1:0]           lane_zero;

    modport slave (
        input  in_valid, exp_offset, significand, sign, cmp_sign1, cmp_sign2, out_ready,
        output in_ready, out_valid, adder_num1, adder_num2, lane_zero
    );

    modport master (
        output in_valid, exp_offset, significand, sign, cmp_sign1, cmp_sign2, out_ready,
        input  in_ready, out_valid, adder_num1, adder_num2, lane_zero
    );
endinterface

// File: rtl/sig_align_pipe.sv
// Two-stage per-lane significand aligner: hidden-bit restore + right shift (stage 1),
// then two's-complement operand generation for both butterfly paths (stage 2).
module sig_align_pipe #(
    parameter int EXP_WIDTH  = 4,
    parameter int SIG_WIDTH  = 4,
    parameter int LOW_EXPAND = 2,
    parameter int LANES      = 4,
    parameter int STICKY_EN  = 0
) (
    input logic       clk,
    input logic       rst,
    sig_align_if.slave bus
);
    localparam int AW = SIG_WIDTH + 4 + LOW_EXPAND;
    localparam int MW = AW - 1;

    // Handshake: a stage loads when it is empty or its contents move on this cycle.
    // A beat transfers only on valid && ready; in_ready never looks at in_valid.
    logic s1_valid, s2_valid;
    logic s1_en, s2_en;

    assign s2_en        = !s2_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;
    assign bus.out_valid = s2_valid;

    function automatic logic [MW-1:0] align_lane(input logic [SIG_WIDTH-1:0] sig,
                                                 input logic [EXP_WIDTH-1:0] off);
        logic [MW-1:0] raw;
        logic [MW-1:0] shifted;
        logic          sticky;
        raw    = {3'b001, sig, {LOW_EXPAND{1'b0}}};
        sticky = 1'b0;
        for (int j = 0; j < MW; j++) begin
            if (j < int'(off)) sticky = sticky | raw[j];
        end
        // Offsets past the magnitude width flush to zero, sticky included.
        if (int'(off) >= MW) begin
            shifted = '0;
        end else begin
            shifted = raw >> off;
            if (STICKY_EN != 0) shifted[0] = shifted[0] | sticky;
        end
        return shifted;
    endfunction

    function automatic logic [AW-1:0] make_operand(input logic [MW-1:0] mag,
                                                   input logic          zero,
                                                   input logic          neg);
        logic [MW-1:0] neg_mag;
        logic [AW-1:0] op;
        neg_mag = ~mag + MW'(1);
        if (zero)     op = '0;
        else if (neg) op = {1'b1, neg_mag};
        else          op = {1'b0, mag};
        return op;
    endfunction

    logic [MW-1:0] mag_d [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mag_d[i] = align_lane(bus.significand[i*SIG_WIDTH +: SIG_WIDTH],
                                  bus.exp_offset[i*EXP_WIDTH +: EXP_WIDTH]);
        end
    end

    logic [MW-1:0]    s1_mag [LANES];
    logic [LANES-1:0] s1_zero;
    logic [LANES-1:0] s1_neg1;
    logic [LANES-1:0] s1_neg2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= '0;
            s1_neg1  <= '0;
            s1_neg2  <= '0;
            for (int i = 0; i < LANES; i++) s1_mag[i] <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_mag[i]  <= mag_d[i];
                    s1_zero[i] <= (mag_d[i] == '0);
                end
                s1_neg1 <= bus.sign ^ bus.cmp_sign1;
                s1_neg2 <= bus.sign ^ bus.cmp_sign2;
            end
        end
    end

    logic [LANES*AW-1:0] num1_q;
    logic [LANES*AW-1:0] num2_q;
    logic [LANES-1:0]    zero_q;

    // Output registers only change when stage 1 hands over a beat, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            num1_q   <= '0;
            num2_q   <= '0;
            zero_q   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    num1_q[i*AW +: AW] <= make_operand(s1_mag[i], s1_zero[i], s1_neg1[i]);
                    num2_q[i*AW +: AW] <= make_operand(s1_mag[i], s1_zero[i], s1_neg2[i]);
                end
                zero_q <= s1_zero;
            end
        end
    end

    assign bus.adder_num1 = num1_q;
    assign bus.adder_num2 = num2_q;
    assign bus.lane_zero  = zero_q;
endmodule

// File: tb/tb_sig_align_pipe.sv
// Directed bench for sig_align_pipe: a plain instance and a sticky-enabled instance
// share one stimulus stream; outputs are compared against hand-computed vectors.
module tb_sig_align_pipe;
    localparam int EW = 4;
    localparam int SW = 4;
    localparam int LE = 2;
    localparam int LN = 4;
    localparam int AW = SW + 4 + LE;

    logic clk;
    logic rst;

    sig_align_if #(.EXP_WIDTH(EW), .SIG_WIDTH(SW), .LOW_EXPAND(LE), .LANES(LN)) bus0 ();
    sig_align_if #(.EXP_WIDTH(EW), .SIG_WIDTH(SW), .LOW_EXPAND(LE), .LANES(LN)) bus1 ();

    sig_align_pipe #(.EXP_WIDTH(EW), .SIG_WIDTH(SW), .LOW_EXPAND(LE), .LANES(LN), .STICKY_EN(0))
        dut_plain (.clk(clk), .rst(rst), .bus(bus0.slave));
    sig_align_pipe #(.EXP_WIDTH(EW), .SIG_WIDTH(SW), .LOW_EXPAND(LE), .LANES(LN), .STICKY_EN(1))
        dut_sticky (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus1.in_valid    = bus0.in_valid;
    assign bus1.exp_offset  = bus0.exp_offset;
    assign bus1.significand = bus0.significand;
    assign bus1.sign        = bus0.sign;
    assign bus1.cmp_sign1   = bus0.cmp_sign1;
    assign bus1.cmp_sign2   = bus0.cmp_sign2;
    assign bus1.out_ready   = bus0.out_ready;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [LN*AW-1:0] exp_q[$];
    int   n_rx      = 0;
    logic mon_en    = 1'b0;
    logic saw_stall = 1'b0;
    logic prev_hold = 1'b0;
    logic [LN*AW-1:0] prev_num1;
    logic [LN*AW-1:0] prev_num2;
    logic [LN-1:0]    prev_zero;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]    sig;
        logic [3:0]    off;
        logic          s, c1, c2;
        logic [AW-1:0] e1, e2;
        logic          ez;
        logic [AW-1:0] t1, t2;
        logic          tz;
    } vec_t;

    vec_t vecs[8];

    initial begin
        //         sig    off   s     c1    c2    e1       e2       ez    t1 (sticky) t2      tz
        vecs[0] = '{4'hA, 4'd0, 1'b0, 1'b0, 1'b1, 10'h068, 10'h398, 1'b0, 10'h068, 10'h398, 1'b0};
        vecs[1] = '{4'hA, 4'd3, 1'b1, 1'b0, 1'b1, 10'h3F3, 10'h00D, 1'b0, 10'h3F3, 10'h00D, 1'b0};
        vecs[2] = '{4'hA, 4'd2, 1'b0, 1'b0, 1'b0, 10'h01A, 10'h01A, 1'b0, 10'h01A, 10'h01A, 1'b0};
        vecs[3] = '{4'hA, 4'd7, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 10'h3FF, 10'h3FF, 1'b0};
        vecs[4] = '{4'hA, 4'd15,1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 10'h000, 10'h000, 1'b1};
        vecs[5] = '{4'h1, 4'd3, 1'b0, 1'b1, 1'b0, 10'h3F8, 10'h008, 1'b0, 10'h3F7, 10'h009, 1'b0};
        vecs[6] = '{4'h0, 4'd8, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 10'h001, 10'h001, 1'b0};
        vecs[7] = '{4'hF, 4'd0, 1'b1, 1'b1, 1'b0, 10'h07C, 10'h384, 1'b0, 10'h07C, 10'h384, 1'b0};
    end

    // ---------------- driver tasks ----------------
    task automatic set_lane(input int l, input logic [3:0] sig, input logic [3:0] off,
                            input logic s, input logic c1, input logic c2);
        bus0.significand[l*SW +: SW] = sig;
        bus0.exp_offset[l*EW +: EW]  = off;
        bus0.sign[l]      = s;
        bus0.cmp_sign1[l] = c1;
        bus0.cmp_sign2[l] = c2;
    endtask

    // Holds the current inputs valid until accepted; called at #1 after a rising edge.
    task automatic push_beat(input logic [LN*AW-1:0] exp_num1);
        logic acc;
        int   waited;
        acc    = 1'b0;
        waited = 0;
        bus0.in_valid = 1'b1;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
        else exp_q.push_back(exp_num1);
    endtask

    task automatic send_stream(input int i);
        logic [AW-1:0]    lane_v;
        logic [LN*AW-1:0] exp_v;
        lane_v = 10'h040 + AW'(i * 4);
        for (int l = 0; l < LN; l++) begin
            set_lane(l, 4'(i), 4'd0, 1'b0, 1'b0, 1'b0);
            exp_v[l*AW +: AW] = lane_v;
        end
        push_beat(exp_v);
    endtask

    // Single beat into an empty pipe, lanes loaded from vecs[base +: 4], checked at latency 2.
    task automatic run_vec_beat(input int base);
        for (int l = 0; l < LN; l++) begin
            set_lane(l, vecs[base+l].sig, vecs[base+l].off, vecs[base+l].s,
                     vecs[base+l].c1, vecs[base+l].c2);
        end
        check("vec_in_ready", 64'(bus0.in_ready), 64'd1);
        bus0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        check("vec_lat1_out_valid", 64'(bus0.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("vec_lat2_out_valid", 64'(bus0.out_valid), 64'd1);
        for (int l = 0; l < LN; l++) begin
            check($sformatf("v%0d_num1", base+l), 64'(bus0.adder_num1[l*AW +: AW]), 64'(vecs[base+l].e1));
            check($sformatf("v%0d_num2", base+l), 64'(bus0.adder_num2[l*AW +: AW]), 64'(vecs[base+l].e2));
            check($sformatf("v%0d_zero", base+l), 64'(bus0.lane_zero[l]), 64'(vecs[base+l].ez));
            check($sformatf("v%0d_sticky_num1", base+l), 64'(bus1.adder_num1[l*AW +: AW]), 64'(vecs[base+l].t1));
            check($sformatf("v%0d_sticky_num2", base+l), 64'(bus1.adder_num2[l*AW +: AW]), 64'(vecs[base+l].t2));
            check($sformatf("v%0d_sticky_zero", base+l), 64'(bus1.lane_zero[l]), 64'(vecs[base+l].tz));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (!bus0.in_ready) saw_stall = 1'b1;
            if (prev_hold) begin
                check("hold_num1", 64'(bus0.adder_num1), 64'(prev_num1));
                check("hold_num2", 64'(bus0.adder_num2), 64'(prev_num2));
                check("hold_zero", 64'(bus0.lane_zero), 64'(prev_zero));
                check("hold_valid", 64'(bus0.out_valid), 64'd1);
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("stream_num1", 64'(bus0.adder_num1), 64'(exp_q.pop_front()));
                    n_rx++;
                end
            end
            prev_hold = bus0.out_valid && !bus0.out_ready;
            prev_num1 = bus0.adder_num1;
            prev_num2 = bus0.adder_num2;
            prev_zero = bus0.lane_zero;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        int stale;
        rst              = 1'b1;
        bus0.in_valid    = 1'b0;
        bus0.out_ready   = 1'b1;
        bus0.exp_offset  = '0;
        bus0.significand = '0;
        bus0.sign        = '0;
        bus0.cmp_sign1   = '0;
        bus0.cmp_sign2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        check("rst_num1", 64'(bus0.adder_num1), 64'd0);
        check("rst_num2", 64'(bus0.adder_num2), 64'd0);
        check("rst_zero", 64'(bus0.lane_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_vec_beat(0);
        run_vec_beat(4);

        // Stream with a 3-cycle downstream stall in the middle.
        exp_q.delete();
        n_rx      = 0;
        saw_stall = 1'b0;
        prev_hold = 1'b0;
        mon_en    = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send_stream(i);
                bus0.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus0.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus0.out_ready = 1'b1;
            end
        join
        waited = 0;
        while (n_rx < 8 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        mon_en = 1'b0;
        check("stream_count", 64'(n_rx), 64'd8);
        check("stream_leftover", 64'(exp_q.size()), 64'd0);
        check("stream_in_ready_dropped", 64'(saw_stall), 64'd1);

        // Reset with two beats in flight.
        for (int l = 0; l < LN; l++) set_lane(l, 4'hA, 4'd0, 1'b0, 1'b0, 1'b1);
        push_beat('0);
        for (int l = 0; l < LN; l++) set_lane(l, 4'h5, 4'd1, 1'b1, 1'b0, 1'b0);
        push_beat('0);
        exp_q.delete();
        bus0.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus0.in_ready), 64'd1);
        check("midrst_num1", 64'(bus0.adder_num1), 64'd0);
        check("midrst_num2", 64'(bus0.adder_num2), 64'd0);
        check("midrst_zero", 64'(bus0.lane_zero), 64'd0);
        check("midrst_sticky_valid", 64'(bus1.out_valid), 64'd0);
        rst   = 1'b0;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus0.out_valid || bus1.out_valid) stale++;
        end
        check("midrst_no_stale", 64'(stale), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
